// File: rtl/button_event_ctrl.sv
// Button event FSM (PRESS/RELEASE/LONG/REPEAT) feeding a one-entry valid/ready output register.
// Events appear one cycle after the sampled edge; an event arriving while the register is stalled is dropped and latches overflow.
module button_event_ctrl #(
  parameter int LONG_TICKS   = 6_000_000,
  parameter int REPEAT_TICKS = 1_200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       debounced_in,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic       held,
  output logic       overflow
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'b00,
    EV_RELEASE = 2'b01,
    EV_LONG    = 2'b10,
    EV_REPEAT  = 2'b11
  } ev_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_vld;
  logic [1:0]      r_code;
  logic            r_held;
  logic            r_ovf;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_ev_gen;
  ev_t             w_ev_code;
  logic            w_load;
  logic            w_drop;
  logic            w_xfer;

  // Release is checked before the threshold so it wins on a coincident edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ev_gen    = 1'b0;
    w_ev_code   = EV_PRESS;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (debounced_in) begin
          w_state_nxt = ST_PRESSED;
          w_ev_gen    = 1'b1;
          w_ev_code   = EV_PRESS;
        end
      end
      ST_PRESSED: begin
        if (!debounced_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_ev_gen    = 1'b1;
          w_ev_code   = EV_RELEASE;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_REPEATING;
          w_cnt_nxt   = '0;
          w_ev_gen    = 1'b1;
          w_ev_code   = EV_LONG;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_REPEATING: begin
        if (!debounced_in) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_ev_gen    = 1'b1;
          w_ev_code   = EV_RELEASE;
        end else if (r_cnt == REPEAT_LAST) begin
          w_cnt_nxt = '0;
          w_ev_gen  = 1'b1;
          w_ev_code = EV_REPEAT;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A transfer in the same cycle frees the slot, so back-to-back events load without a bubble.
  assign w_xfer = r_vld && event_ready;
  assign w_load = w_ev_gen && (!r_vld || event_ready);
  assign w_drop = w_ev_gen && r_vld && !event_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_vld   <= 1'b0;
      r_code  <= 2'b00;
      r_held  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_held  <= (w_state_nxt != ST_IDLE);
      if (w_load) begin
        r_vld  <= 1'b1;
        r_code <= w_ev_code;
      end else if (w_xfer) begin
        r_vld <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign event_valid = r_vld;
  assign event_code  = r_code;
  assign held        = r_held;
  assign overflow    = r_ovf;

endmodule
